// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone RAM slave.
package wb_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    function automatic int unsigned wb_bytes(input int unsigned width);
        return width / 8;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4); loads seed on reset, advances on step.
module wb_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_q <= seed;
        else if (step)
            r_q <= {r_q[6:0], w_fb};
    end

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone classic RAM slave with wait states, err on misaligned/out-of-range, saturating counters.
// Define WB_WAIT_RAND_EN to add 0..3 LFSR-driven extra wait states per request.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ERR_ON_OOR  = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic [31:0]            adr,
    input  logic [BUS_WIDTH/8-1:0] sel,
    input  logic [BUS_WIDTH-1:0]   datSlvIn,
    input  logic                   we,
    output logic [BUS_WIDTH-1:0]   datMstIn,
    output logic                   ack,
    output logic                   err,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int unsigned BYTES = wb_bytes(BUS_WIDTH);
    localparam int unsigned AL    = $clog2(BYTES);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [32:0] WIN   = 33'(DEPTH * BYTES);

    logic [7:0] mem [DEPTH][BYTES];

    wb_state_e              r_state;
    logic [4:0]             r_wcnt;
    logic                   r_we;
    logic                   r_bad;
    logic                   r_oor;
    logic [BYTES-1:0]       r_sel;
    logic [BUS_WIDTH-1:0]   r_wdat;
    logic [ADDR_WIDTH-1:0]  r_idx;

    logic [31:0]            w_off;
    logic                   w_mis;
    logic                   w_oor;
    logic                   w_bad;
    logic                   w_accept;
    logic [4:0]             w_wait;

    assign w_off    = adr - BASE_ADDR;
    assign w_mis    = (adr & 32'(BYTES - 1)) != '0;
    assign w_oor    = {1'b0, w_off} >= WIN;
    assign w_bad    = w_mis | (w_oor & (ERR_ON_OOR != 0));
    assign w_accept = (r_state == IDLE) && cyc && stb;

`ifdef WB_WAIT_RAND_EN
    logic [7:0] w_lfsr;

    wb_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .step  (w_accept),
        .q     (w_lfsr)
    );

    assign w_wait = 5'(WAIT_STATES) + 5'(w_lfsr[1:0]);
`else
    assign w_wait = 5'(WAIT_STATES);
`endif

    // Zero-wait requests complete straight from IDLE, so the response path
    // takes the live bus fields then and the latched fields otherwise.
    logic                   w_go_resp;
    logic                   w_c_we;
    logic                   w_c_bad;
    logic                   w_c_oor;
    logic [BYTES-1:0]       w_c_sel;
    logic [BUS_WIDTH-1:0]   w_c_wdat;
    logic [ADDR_WIDTH-1:0]  w_c_idx;
    logic [BUS_WIDTH-1:0]   w_rdata;
    logic                   w_wr_en;

    always_comb begin
        w_go_resp = 1'b0;
        w_c_we    = r_we;
        w_c_bad   = r_bad;
        w_c_oor   = r_oor;
        w_c_sel   = r_sel;
        w_c_wdat  = r_wdat;
        w_c_idx   = r_idx;
        if (r_state == IDLE) begin
            w_c_we    = we;
            w_c_bad   = w_bad;
            w_c_oor   = w_oor;
            w_c_sel   = sel;
            w_c_wdat  = datSlvIn;
            w_c_idx   = w_off[AL +: ADDR_WIDTH];
            w_go_resp = w_accept && (w_wait == '0);
        end else if (r_state == WAIT) begin
            w_go_resp = cyc && (r_wcnt == 5'd1);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < BYTES; i++)
            w_rdata[8*i +: 8] = mem[w_c_idx][i];
    end

    assign w_wr_en = rst_n && w_go_resp && w_c_we && !w_c_bad && !w_c_oor;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTES; i++)
            if (w_wr_en && w_c_sel[i])
                mem[w_c_idx][i] <= w_c_wdat[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wcnt   <= '0;
            r_we     <= 1'b0;
            r_bad    <= 1'b0;
            r_oor    <= 1'b0;
            r_sel    <= '0;
            r_wdat   <= '0;
            r_idx    <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            datMstIn <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err_cnt  <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_we    <= we;
                    r_bad   <= w_bad;
                    r_oor   <= w_oor;
                    r_sel   <= sel;
                    r_wdat  <= datSlvIn;
                    r_idx   <= w_off[AL +: ADDR_WIDTH];
                    r_wcnt  <= w_wait;
                    r_state <= (w_wait == '0) ? RESP : WAIT;
                end
                WAIT: begin
                    if (!cyc)
                        r_state <= IDLE;
                    else if (r_wcnt == 5'd1)
                        r_state <= RESP;
                    else
                        r_wcnt <= r_wcnt - 5'd1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_go_resp) begin
                if (w_c_bad) begin
                    err     <= 1'b1;
                    err_cnt <= sat_inc(err_cnt);
                end else begin
                    ack <= 1'b1;
                    if (w_c_we) begin
                        wr_cnt <= sat_inc(wr_cnt);
                    end else begin
                        rd_cnt   <= sat_inc(rd_cnt);
                        datMstIn <= w_c_oor ? '0 : w_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: three instances (base offset, 3 wait states, OOR-ack mode).
module tb_wb_slave_ram;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] adr   [3];
    logic [31:0] dsi   [3];
    logic [31:0] dmo   [3];
    logic [3:0]  sel   [3];
    logic        ack   [3];
    logic        err   [3];
    logic [15:0] rdc   [3];
    logic [15:0] wrc   [3];
    logic [15:0] erc   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_slave_ram #(.BASE_ADDR(32'h1000), .WAIT_STATES(0), .ERR_ON_OOR(1)) u_d0 (
        .clk(clk), .rst_n(rst_n[0]), .cyc(cyc[0]), .stb(stb[0]), .adr(adr[0]), .sel(sel[0]),
        .datSlvIn(dsi[0]), .we(we[0]), .datMstIn(dmo[0]), .ack(ack[0]), .err(err[0]),
        .rd_cnt(rdc[0]), .wr_cnt(wrc[0]), .err_cnt(erc[0]));

    wb_slave_ram #(.BASE_ADDR(32'h0), .WAIT_STATES(3), .ERR_ON_OOR(1)) u_d1 (
        .clk(clk), .rst_n(rst_n[1]), .cyc(cyc[1]), .stb(stb[1]), .adr(adr[1]), .sel(sel[1]),
        .datSlvIn(dsi[1]), .we(we[1]), .datMstIn(dmo[1]), .ack(ack[1]), .err(err[1]),
        .rd_cnt(rdc[1]), .wr_cnt(wrc[1]), .err_cnt(erc[1]));

    wb_slave_ram #(.BASE_ADDR(32'h0), .WAIT_STATES(1), .ERR_ON_OOR(0)) u_d2 (
        .clk(clk), .rst_n(rst_n[2]), .cyc(cyc[2]), .stb(stb[2]), .adr(adr[2]), .sel(sel[2]),
        .datSlvIn(dsi[2]), .we(we[2]), .datMstIn(dmo[2]), .ack(ack[2]), .err(err[2]),
        .rd_cnt(rdc[2]), .wr_cnt(wrc[2]), .err_cnt(erc[2]));

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (ack[d] && err[d]) begin
                n_fail++;
                $display("FAIL ack_err_excl dut%0d: ack=%b err=%b, required not both 1", d, ack[d], err[d]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        adr[d] = '0; sel[d] = '0; dsi[d] = '0;
    endtask

    // One transfer; lat = cycles from the sampling edge to the first edge after which ack/err is seen.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output logic ga,
                        output logic ge, output int lat);
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dsi[d] = wd;
        ga = 1'b0; ge = 1'b0; lat = 0; rd = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[d] || err[d]) begin
                ga = ack[d]; ge = err[d]; rd = dmo[d];
                break;
            end
        end
        idle_bus(d);
    endtask

    task automatic quiet(input int d, input int ncyc, input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (ack[d] || err[d]) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] wd;
        logic        e_ack;
        logic        e_err;
        logic        chk_rd;
        logic [31:0] e_rd;
        int          e_lat;
    } vec_t;

    vec_t vt [23];

    initial begin
        logic [31:0] rd;
        logic        ga, ge;
        int          lat;
        int          acks;

        //           d  w     adr            sel    wdat           ack   err   chk   exp_rd         lat
        vt[0]  = '{0, 1'b1, 32'h0000_1010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[1]  = '{0, 1'b0, 32'h0000_1010, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1};
        vt[2]  = '{0, 1'b1, 32'h0000_1020, 4'hF, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[3]  = '{0, 1'b1, 32'h0000_1020, 4'h5, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[4]  = '{0, 1'b0, 32'h0000_1020, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11BB33DD, 1};
        vt[5]  = '{0, 1'b1, 32'h0000_1010, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[6]  = '{0, 1'b0, 32'h0000_1010, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1};
        vt[7]  = '{0, 1'b0, 32'h0000_1012, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1};
        vt[8]  = '{0, 1'b1, 32'h0000_1000, 4'hF, 32'h01020304, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[9]  = '{0, 1'b1, 32'h0000_2000, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,        1};
        vt[10] = '{0, 1'b1, 32'h0000_0FFC, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,        1};
        vt[11] = '{0, 1'b0, 32'h0000_1000, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h01020304, 1};
        vt[12] = '{0, 1'b1, 32'h0000_1FFC, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h0,        1};
        vt[13] = '{0, 1'b0, 32'h0000_1FFC, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1};
        vt[14] = '{0, 1'b1, 32'h0000_1011, 4'hF, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h0,        1};
        vt[15] = '{0, 1'b0, 32'h0000_1010, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1};
        vt[16] = '{2, 1'b1, 32'h0000_0000, 4'hF, 32'h0BADC0DE, 1'b1, 1'b0, 1'b0, 32'h0,        2};
        vt[17] = '{2, 1'b0, 32'h0000_1000, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00000000, 2};
        vt[18] = '{2, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        2};
        vt[19] = '{2, 1'b0, 32'h0000_0000, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0BADC0DE, 2};
        vt[20] = '{2, 1'b0, 32'h0000_0002, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0BADC0DE, 2};
        vt[21] = '{1, 1'b1, 32'h0000_0040, 4'hF, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0,        4};
        vt[22] = '{1, 1'b0, 32'h0000_0040, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678, 4};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            idle_bus(d);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ack_d%0d", d), 32'(ack[d]), 32'd0);
            chk($sformatf("reset_err_d%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("reset_dat_d%0d", d), dmo[d], 32'd0);
            chk($sformatf("reset_cnts_d%0d", d), 32'(rdc[d] | wrc[d] | erc[d]), 32'd0);
            rst_n[d] = 1'b1;
        end

        for (int i = 0; i < 23; i++) begin
            xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].s, vt[i].wd, rd, ga, ge, lat);
            chk($sformatf("v%0d_ack", i), 32'(ga), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_err", i), 32'(ge), 32'(vt[i].e_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
            if (vt[i].chk_rd)
                chk($sformatf("v%0d_rdata", i), rd, vt[i].e_rd);
        end

        chk("d0_wr_cnt", 32'(wrc[0]), 32'd6);
        chk("d0_rd_cnt", 32'(rdc[0]), 32'd6);
        chk("d0_err_cnt", 32'(erc[0]), 32'd4);
        chk("d2_wr_cnt", 32'(wrc[2]), 32'd2);
        chk("d2_rd_cnt", 32'(rdc[2]), 32'd2);
        chk("d2_err_cnt", 32'(erc[2]), 32'd1);
        chk("d1_wr_cnt", 32'(wrc[1]), 32'd1);
        chk("d1_rd_cnt", 32'(rdc[1]), 32'd1);

        // Back-to-back: stb held through ack -> one transfer every 2 cycles.
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h1020; sel[0] = 4'hF;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ack_c%0d", k), 32'(ack[0]), 32'((k % 2) == 0));
            if (ack[0]) acks++;
        end
        idle_bus(0);
        chk("b2b_data", dmo[0], 32'h11BB33DD);
        chk("b2b_rd_cnt", 32'(rdc[0]), 32'd9);

        // Abort during WAIT: cyc dropped before the response edge.
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = (t == 1); adr[1] = 32'h40; sel[1] = 4'hF;
            dsi[1] = 32'hFFFFFFFF;
            @(posedge clk); #1;
            @(posedge clk); #1;
            idle_bus(1);
            quiet(1, 8, $sformatf("abort%0d_no_resp", t));
        end
        chk("abort_wr_cnt", 32'(wrc[1]), 32'd1);
        chk("abort_rd_cnt", 32'(rdc[1]), 32'd1);
        chk("abort_err_cnt", 32'(erc[1]), 32'd0);
        xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, rd, ga, ge, lat);
        chk("abort_readback", rd, 32'h12345678);
        chk("abort_readback_ack", 32'(ga), 32'd1);

        // Reset asserted while a write sits in WAIT.
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF;
        dsi[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        idle_bus(1);
        chk("rst_mid_ack", 32'(ack[1]), 32'd0);
        quiet(1, 6, "rst_mid_no_resp");
        chk("rst_mid_cnts", 32'(rdc[1] | wrc[1] | erc[1]), 32'd0);
        xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, rd, ga, ge, lat);
        chk("rst_mid_word", rd, 32'h12345678);
        chk("rst_mid_lat", 32'(lat), 32'd4);
        chk("rst_mid_rd_cnt", 32'(rdc[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
